// File: rtl/raptor64_pkg.sv
// Shared Raptor64 pipeline definitions: register numbering, special register
// codes and the default bubble instruction.
package raptor64_pkg;

  localparam int unsigned REG_W     = 9;
  localparam int unsigned MD_CNT_W  = 4;
  localparam int unsigned IR_W_DEF  = 42;

  typedef logic [REG_W-1:0]    reg_num_t;
  typedef logic [MD_CNT_W-1:0] md_cnt_t;

  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam logic [4:0] PC_REG   = 5'd29;

  localparam logic [IR_W_DEF-1:0] NOP_IR_DEFAULT = '0;

  // Zero and PC reads never wait on a producer, whatever the upper bits hold.
  function automatic logic is_exempt(input reg_num_t src, input logic use_src);
    return !use_src || (src[4:0] == ZERO_REG) || (src[4:0] == PC_REG);
  endfunction

endpackage

// File: rtl/raptor64_src_hazard.sv
// Hazard detect for one decode source operand against in-flight loads and
// the outstanding multiply/divide.
module raptor64_src_hazard
  import raptor64_pkg::*;
(
  input  logic [REG_W-1:0]    src,
  input  logic                use_src,
  input  logic [REG_W-1:0]    x_rt,
  input  logic                x_is_load,
  input  logic [REG_W-1:0]    m1_rt,
  input  logic                m1_is_load,
  input  logic [REG_W-1:0]    md_rt,
  input  logic                md_busy,
  input  logic [MD_CNT_W-1:0] md_cnt,
  output logic                hazard
);

  logic load_hz;
  logic md_hz;

  // Load data only becomes forwardable from M2, so X and M1 both block.
  assign load_hz = (x_is_load && (src == x_rt)) || (m1_is_load && (src == m1_rt));
  // At count 1 the MD result reaches the X bypass next cycle.
  assign md_hz   = md_busy && (src == md_rt) && (md_cnt > md_cnt_t'(1));
  assign hazard  = !is_exempt(src, use_src) && (load_hz || md_hz);

endmodule

// File: rtl/raptor64_operand_latch.sv
// Decode->execute operand latch: captures bypassed operands, interlocks on
// load-use and multiply/divide hazards, and inserts bubbles.
module raptor64_operand_latch
  import raptor64_pkg::*;
#(
  parameter int unsigned    IR_W   = 42,
  parameter logic [IR_W-1:0] NOP_IR = {IR_W{1'b0}},
  parameter int unsigned    MD_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dValid,
  input  logic [IR_W-1:0]  dIR,
  input  logic [8:0]       dRa,
  input  logic [8:0]       dRb,
  input  logic [8:0]       dRc,
  input  logic             dUseA,
  input  logic             dUseB,
  input  logic             dUseC,
  input  logic             dIsMD,
  input  logic [63:0]      nxt_a,
  input  logic [63:0]      nxt_b,
  input  logic [63:0]      nxt_c,
  input  logic [8:0]       xRt,
  input  logic [8:0]       m1Rt,
  input  logic             xIsLoad,
  input  logic             m1IsLoad,
  input  logic             xStall,
  output logic             advanceR,
  output logic             xValid,
  output logic [IR_W-1:0]  xIR,
  output logic [63:0]      xA,
  output logic [63:0]      xB,
  output logic [63:0]      xC,
  output logic             mdBusy,
  output logic [8:0]       mdRt
);

  localparam md_cnt_t MD_LAT_CNT = md_cnt_t'(MD_LAT);

  md_cnt_t mdCnt;
  logic    hz_a, hz_b, hz_c;
  logic    struct_hz;
  logic    hz;
  logic    md_issue;

  raptor64_src_hazard u_hz_a (
    .src(dRa), .use_src(dUseA), .x_rt(xRt), .x_is_load(xIsLoad),
    .m1_rt(m1Rt), .m1_is_load(m1IsLoad), .md_rt(mdRt), .md_busy(mdBusy),
    .md_cnt(mdCnt), .hazard(hz_a)
  );

  raptor64_src_hazard u_hz_b (
    .src(dRb), .use_src(dUseB), .x_rt(xRt), .x_is_load(xIsLoad),
    .m1_rt(m1Rt), .m1_is_load(m1IsLoad), .md_rt(mdRt), .md_busy(mdBusy),
    .md_cnt(mdCnt), .hazard(hz_b)
  );

  raptor64_src_hazard u_hz_c (
    .src(dRc), .use_src(dUseC), .x_rt(xRt), .x_is_load(xIsLoad),
    .m1_rt(m1Rt), .m1_is_load(m1IsLoad), .md_rt(mdRt), .md_busy(mdBusy),
    .md_cnt(mdCnt), .hazard(hz_c)
  );

  // A second MD may only issue once the first is on its final cycle.
  assign struct_hz = dIsMD && mdBusy && (mdCnt != md_cnt_t'(1));
  assign hz        = dValid && (hz_a || hz_b || hz_c || struct_hz);
  assign advanceR  = !xStall && !hz;
  assign md_issue  = advanceR && dValid && dIsMD;
  assign mdBusy    = (mdCnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xValid <= 1'b0;
      xIR    <= NOP_IR;
      xA     <= '0;
      xB     <= '0;
      xC     <= '0;
    end else if (!xStall) begin
      if (hz) begin
        xValid <= 1'b0;
        xIR    <= NOP_IR;
        xA     <= '0;
        xB     <= '0;
        xC     <= '0;
      end else begin
        xValid <= dValid;
        xIR    <= dIR;
        xA     <= nxt_a;
        xB     <= nxt_b;
        xC     <= nxt_c;
      end
    end
  end

  // The MD counter runs on regardless of execute stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdCnt <= '0;
      mdRt  <= '0;
    end else if (md_issue) begin
      mdCnt <= MD_LAT_CNT;
      mdRt  <= dRc;
    end else if (mdCnt != '0) begin
      mdCnt <= mdCnt - md_cnt_t'(1);
    end
  end

endmodule

// File: tb/tb_raptor64_operand_latch.sv
// Directed bench for raptor64_operand_latch: ALU flow, load interlock,
// exemptions, MD interlock, hold and asynchronous reset.
module tb_raptor64_operand_latch;

  localparam int unsigned    IR_W = 42;
  localparam logic [IR_W-1:0] NOP  = 42'h2AA00000013;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dValid;
  logic [IR_W-1:0] dIR;
  logic [8:0]      dRa, dRb, dRc;
  logic            dUseA, dUseB, dUseC, dIsMD;
  logic [63:0]     nxt_a, nxt_b, nxt_c;
  logic [8:0]      xRt, m1Rt;
  logic            xIsLoad, m1IsLoad, xStall;
  logic            advanceR, xValid, mdBusy;
  logic [IR_W-1:0] xIR;
  logic [63:0]     xA, xB, xC;
  logic [8:0]      mdRt;

  int checks = 0;
  int errors = 0;

  raptor64_operand_latch #(.IR_W(IR_W), .NOP_IR(NOP), .MD_LAT(8)) dut (
    .clk(clk), .rst_n(rst_n), .dValid(dValid), .dIR(dIR),
    .dRa(dRa), .dRb(dRb), .dRc(dRc), .dUseA(dUseA), .dUseB(dUseB), .dUseC(dUseC),
    .dIsMD(dIsMD), .nxt_a(nxt_a), .nxt_b(nxt_b), .nxt_c(nxt_c),
    .xRt(xRt), .m1Rt(m1Rt), .xIsLoad(xIsLoad), .m1IsLoad(m1IsLoad), .xStall(xStall),
    .advanceR(advanceR), .xValid(xValid), .xIR(xIR), .xA(xA), .xB(xB), .xC(xC),
    .mdBusy(mdBusy), .mdRt(mdRt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; dValid = 1'b0; dIR = '0;
    dRa = '0; dRb = '0; dRc = '0; dUseA = 1'b0; dUseB = 1'b0; dUseC = 1'b0;
    dIsMD = 1'b0; nxt_a = '0; nxt_b = '0; nxt_c = '0;
    xRt = '0; m1Rt = '0; xIsLoad = 1'b0; m1IsLoad = 1'b0; xStall = 1'b0;

    #12;
    check("rst_xValid", 64'(xValid), 64'd0);
    check("rst_xIR",    64'(xIR),    64'(NOP));
    check("rst_xA",     xA,          64'd0);
    check("rst_xC",     xC,          64'd0);
    check("rst_mdBusy", 64'(mdBusy), 64'd0);
    check("rst_mdRt",   64'(mdRt),   64'd0);
    rst_n = 1'b1;

    // Back-to-back independent ALU ops
    dValid = 1'b1; dIR = 42'h100; dRa = 9'd3; dRb = 9'd4; dRc = 9'd6;
    dUseA = 1'b1; dUseB = 1'b1;
    nxt_a = 64'hA1; nxt_b = 64'hB1; nxt_c = 64'hC1;
    #1 check("alu1_adv", 64'(advanceR), 64'd1);
    tick();
    check("alu1_xValid", 64'(xValid), 64'd1);
    check("alu1_xIR",    64'(xIR),    64'h100);
    check("alu1_xA",     xA,          64'hA1);
    check("alu1_xB",     xB,          64'hB1);
    check("alu1_xC",     xC,          64'hC1);
    dIR = 42'h101; nxt_a = 64'hA2; nxt_b = 64'hB2;
    #1 check("alu2_adv", 64'(advanceR), 64'd1);
    tick();
    check("alu2_xIR", 64'(xIR), 64'h101);
    check("alu2_xA",  xA,       64'hA2);

    // Load in X reading r5: two bubbles, issue on the third cycle
    dIR = 42'h102; dRa = 9'd5; nxt_a = 64'hA3;
    xRt = 9'd5; xIsLoad = 1'b1;
    #1 check("ldx_adv", 64'(advanceR), 64'd0);
    tick();
    check("ldx_bub_valid", 64'(xValid), 64'd0);
    check("ldx_bub_ir",    64'(xIR),    64'(NOP));
    check("ldx_bub_xA",    xA,          64'd0);
    xRt = 9'd9; xIsLoad = 1'b0; m1Rt = 9'd5; m1IsLoad = 1'b1;
    #1 check("ldm1_adv", 64'(advanceR), 64'd0);
    tick();
    check("ldm1_bub_valid", 64'(xValid), 64'd0);
    check("ldm1_bub_ir",    64'(xIR),    64'(NOP));
    m1IsLoad = 1'b0;
    #1 check("ldm2_adv", 64'(advanceR), 64'd1);
    tick();
    check("ld_issue_ir", 64'(xIR), 64'h102);
    check("ld_issue_xA", xA,       64'hA3);

    // Exempt sources: r0 (incl. upper bits set) and r29 under matching loads
    dIR = 42'h103; dRa = 9'h020; dRb = 9'd29; nxt_a = 64'hA4;
    xRt = 9'h020; xIsLoad = 1'b1; m1Rt = 9'd29; m1IsLoad = 1'b1;
    #1 check("exempt_adv", 64'(advanceR), 64'd1);
    tick();
    check("exempt_ir", 64'(xIR), 64'h103);

    // Use bit clear on a matching source; upper-bit mismatch is not a match
    dIR = 42'h104; dRa = 9'd5; dUseA = 1'b0; dRb = 9'h105; m1IsLoad = 1'b0;
    xRt = 9'd5; xIsLoad = 1'b1;
    #1 check("usebit_adv", 64'(advanceR), 64'd1);
    tick();
    check("usebit_ir", 64'(xIR), 64'h104);
    dUseA = 1'b1; dRb = 9'd4;
    #1 check("usebit_set_adv", 64'(advanceR), 64'd0);
    xIsLoad = 1'b0;

    // MD to r7, dependent MD reading r7 stalls 7 cycles then reloads counter
    dIR = 42'h105; dIsMD = 1'b1; dRa = 9'd3; dRc = 9'd7; nxt_a = 64'hA5;
    #1 check("md_adv", 64'(advanceR), 64'd1);
    tick();
    check("md_busy",  64'(mdBusy), 64'd1);
    check("md_rt",    64'(mdRt),   64'd7);
    check("md_xIR",   64'(xIR),    64'h105);
    dIR = 42'h106; dRa = 9'd7; dRc = 9'd8; nxt_a = 64'hA6;
    for (int i = 0; i < 7; i++) begin
      #1 check("mddep_adv", 64'(advanceR), 64'd0);
      tick();
      check("mddep_bub", 64'(xValid), 64'd0);
    end
    #1 check("mddep_go_adv", 64'(advanceR), 64'd1);
    check("mddep_go_busy", 64'(mdBusy), 64'd1);
    tick();
    check("mddep_ir",     64'(xIR),    64'h106);
    check("mddep_xA",     xA,          64'hA6);
    check("mdre_busy",    64'(mdBusy), 64'd1);
    check("mdre_rt",      64'(mdRt),   64'd8);

    // Structural: another independent MD while the counter is at 8
    dIR = 42'h107; dRa = 9'd3; dRc = 9'd10;
    #1 check("struct_adv", 64'(advanceR), 64'd0);

    // Hold: xStall with a load hazard keeps X unchanged, no bubble
    dIsMD = 1'b0; dRa = 9'd5; xRt = 9'd5; xIsLoad = 1'b1; xStall = 1'b1;
    #1 check("hold_adv", 64'(advanceR), 64'd0);
    tick();
    check("hold_valid", 64'(xValid), 64'd1);
    check("hold_ir",    64'(xIR),    64'h106);
    check("hold_xA",    xA,          64'hA6);
    check("hold_busy",  64'(mdBusy), 64'd1);
    xIsLoad = 1'b0;
    #1 check("stall_only_adv", 64'(advanceR), 64'd0);

    // Asynchronous reset mid-MD, away from any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy",  64'(mdBusy), 64'd0);
    check("arst_rt",    64'(mdRt),   64'd0);
    check("arst_valid", 64'(xValid), 64'd0);
    check("arst_ir",    64'(xIR),    64'(NOP));
    check("arst_xA",    xA,          64'd0);
    rst_n = 1'b1; xStall = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
